// File: rtl/mont_pow_ctrl.sv
// rtl/mont_pow_ctrl.sv - left-to-right square-and-multiply controller driving a Montgomery multiplier
// Optional leading-zero skip: define MONT_POW_SKIP_LZ_EN.
module mont_pow_ctrl #(
    parameter int WIDTH    = 260,
    parameter int EXP_BITS = 256
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] base,
    input  logic [WIDTH-1:0] exp,
    input  logic [WIDTH-1:0] m,
    input  logic [WIDTH-1:0] r2,
    output logic [WIDTH-1:0] result,
    output logic             done,
    output logic             mul_start,
    output logic [WIDTH-1:0] mul_a,
    output logic [WIDTH-1:0] mul_b,
    output logic [WIDTH-1:0] mul_m,
    input  logic [WIDTH-1:0] mul_result,
    input  logic             mul_done
);

    localparam int IW = (EXP_BITS > 1) ? $clog2(EXP_BITS) : 1;
    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CONV_BASE,
        S_INIT_ACC,
        S_SQR,
        S_MUL,
        S_NEXT,
        S_FINAL,
        S_DONE
    } state_t;

    // Each multiplying state runs through these phases; PREP holds off until the multiplier is idle.
    typedef enum logic [1:0] {
        P_PREP,
        P_ISSUE,
        P_WAIT_LO,
        P_WAIT_HI
    } phase_t;

    state_t              state_q, state_d;
    phase_t              phase_q, phase_d;
    logic [WIDTH-1:0]    base_q, base_d;
    logic [EXP_BITS-1:0] exp_q, exp_d;
    logic [WIDTH-1:0]    m_q, m_d;
    logic [WIDTH-1:0]    r2_q, r2_d;
    logic [WIDTH-1:0]    xb_q, xb_d;
    logic [WIDTH-1:0]    acc_q, acc_d;
    logic [IW-1:0]       idx_q, idx_d;
    logic [WIDTH-1:0]    result_q, result_d;
    logic                done_q, done_d;
    logic                mul_start_q, mul_start_d;
    logic [WIDTH-1:0]    mul_a_q, mul_a_d;
    logic [WIDTH-1:0]    mul_b_q, mul_b_d;
    logic [WIDTH-1:0]    mul_m_q, mul_m_d;
    logic [WIDTH-1:0]    op_a, op_b;
    logic                skip;
`ifdef MONT_POW_SKIP_LZ_EN
    logic                seen_q, seen_d;
`endif

    generate
        if (WIDTH > EXP_BITS) begin : g_exp_hi
            logic unused_exp_hi;
            assign unused_exp_hi = ^exp[WIDTH-1:EXP_BITS];
        end
    endgenerate

    assign result    = result_q;
    assign done      = done_q;
    assign mul_start = mul_start_q;
    assign mul_a     = mul_a_q;
    assign mul_b     = mul_b_q;
    assign mul_m     = mul_m_q;

    always_comb begin
        op_a = '0;
        op_b = '0;
        case (state_q)
            S_CONV_BASE: begin op_a = base_q; op_b = r2_q; end
            S_INIT_ACC:  begin op_a = ONE;    op_b = r2_q; end
            S_SQR:       begin op_a = acc_q;  op_b = acc_q; end
            S_MUL:       begin op_a = acc_q;  op_b = xb_q; end
            S_FINAL:     begin op_a = acc_q;  op_b = ONE; end
            default:     begin op_a = '0;     op_b = '0; end
        endcase
    end

    // Before the first set bit acc is still R mod m, so squaring it changes nothing.
    always_comb begin
        skip = 1'b0;
`ifdef MONT_POW_SKIP_LZ_EN
        skip = (state_q == S_SQR) && !seen_q && !exp_q[idx_q];
`endif
    end

    always_comb begin
        state_d     = state_q;
        phase_d     = phase_q;
        base_d      = base_q;
        exp_d       = exp_q;
        m_d         = m_q;
        r2_d        = r2_q;
        xb_d        = xb_q;
        acc_d       = acc_q;
        idx_d       = idx_q;
        result_d    = result_q;
        done_d      = done_q;
        mul_start_d = 1'b0;
        mul_a_d     = mul_a_q;
        mul_b_d     = mul_b_q;
        mul_m_d     = mul_m_q;
`ifdef MONT_POW_SKIP_LZ_EN
        seen_d      = seen_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    base_d  = base;
                    exp_d   = exp[EXP_BITS-1:0];
                    m_d     = m;
                    r2_d    = r2;
                    done_d  = 1'b0;
                    state_d = S_CONV_BASE;
                    phase_d = P_PREP;
`ifdef MONT_POW_SKIP_LZ_EN
                    seen_d  = 1'b0;
`endif
                end else begin
                    done_d = 1'b1;
                end
            end
            S_CONV_BASE, S_INIT_ACC, S_SQR, S_MUL, S_FINAL: begin
                case (phase_q)
                    P_PREP: begin
                        if (skip) begin
                            state_d = S_NEXT;
                        end else if (mul_done) begin
                            mul_a_d     = op_a;
                            mul_b_d     = op_b;
                            mul_m_d     = m_q;
                            mul_start_d = 1'b1;
                            phase_d     = P_ISSUE;
`ifdef MONT_POW_SKIP_LZ_EN
                            if (state_q == S_SQR) seen_d = 1'b1;
`endif
                        end
                    end
                    P_ISSUE: phase_d = P_WAIT_LO;
                    P_WAIT_LO: begin
                        if (!mul_done) phase_d = P_WAIT_HI;
                    end
                    P_WAIT_HI: begin
                        if (mul_done) begin
                            phase_d = P_PREP;
                            case (state_q)
                                S_CONV_BASE: begin
                                    xb_d    = mul_result;
                                    state_d = S_INIT_ACC;
                                end
                                S_INIT_ACC: begin
                                    acc_d   = mul_result;
                                    idx_d   = IW'(EXP_BITS - 1);
                                    state_d = S_SQR;
                                end
                                S_SQR: begin
                                    acc_d   = mul_result;
                                    state_d = exp_q[idx_q] ? S_MUL : S_NEXT;
                                end
                                S_MUL: begin
                                    acc_d   = mul_result;
                                    state_d = S_NEXT;
                                end
                                default: begin
                                    acc_d   = mul_result;
                                    state_d = S_DONE;
                                end
                            endcase
                        end
                    end
                    default: phase_d = P_PREP;
                endcase
            end
            S_NEXT: begin
                phase_d = P_PREP;
                if (idx_q == '0) begin
                    state_d = S_FINAL;
                end else begin
                    idx_d   = idx_q - 1'b1;
                    state_d = S_SQR;
                end
            end
            S_DONE: begin
                result_d = acc_q;
                done_d   = 1'b1;
                state_d  = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            phase_q     <= P_PREP;
            base_q      <= '0;
            exp_q       <= '0;
            m_q         <= '0;
            r2_q        <= '0;
            xb_q        <= '0;
            acc_q       <= '0;
            idx_q       <= '0;
            result_q    <= '0;
            done_q      <= 1'b0;
            mul_start_q <= 1'b0;
            mul_a_q     <= '0;
            mul_b_q     <= '0;
            mul_m_q     <= '0;
`ifdef MONT_POW_SKIP_LZ_EN
            seen_q      <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            phase_q     <= phase_d;
            base_q      <= base_d;
            exp_q       <= exp_d;
            m_q         <= m_d;
            r2_q        <= r2_d;
            xb_q        <= xb_d;
            acc_q       <= acc_d;
            idx_q       <= idx_d;
            result_q    <= result_d;
            done_q      <= done_d;
            mul_start_q <= mul_start_d;
            mul_a_q     <= mul_a_d;
            mul_b_q     <= mul_b_d;
            mul_m_q     <= mul_m_d;
`ifdef MONT_POW_SKIP_LZ_EN
            seen_q      <= seen_d;
`endif
        end
    end

endmodule

// File: tb/tb_mont_pow_ctrl.sv
// tb/tb_mont_pow_ctrl.sv - scoreboard bench for mont_pow_ctrl with a behavioural Montgomery multiplier
module tb_mont_pow_ctrl;

    localparam int W  = 260;
    localparam int EB = 256;

    logic         clk;
    logic         reset;
    logic         start;
    logic [W-1:0] base, exp, m, r2;
    logic [W-1:0] result;
    logic         done;
    logic         mul_start;
    logic [W-1:0] mul_a, mul_b, mul_m;
    logic [W-1:0] mul_result;
    logic         mul_done;

    mont_pow_ctrl #(.WIDTH(W), .EXP_BITS(EB)) dut (
        .clk(clk), .reset(reset), .start(start),
        .base(base), .exp(exp), .m(m), .r2(r2),
        .result(result), .done(done),
        .mul_start(mul_start), .mul_a(mul_a), .mul_b(mul_b), .mul_m(mul_m),
        .mul_result(mul_result), .mul_done(mul_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string        name;
        logic [W-1:0] act;
        logic [W-1:0] expv;
    } chk_t;

    typedef struct {
        logic [W-1:0] res;
        int           pulses;
    } job_t;

    chk_t chk_q[$];
    job_t job_q[$];
    int   checks = 0;
    int   errors = 0;
    int   pulse_cnt;
    int   pulse_base = 0;
    logic done_prev = 1'b0;
    logic [W-1:0] last_res;

    // a*b*2^-256 mod mm, bit-serial
    function automatic logic [W-1:0] mont(input logic [W-1:0] a, input logic [W-1:0] b,
                                          input logic [W-1:0] mm);
        logic [W+1:0] t;
        t = '0;
        for (int k = 0; k < 256; k++) begin
            if (a[k]) t = t + {2'b00, b};
            if (t[0]) t = t + {2'b00, mm};
            t = t >> 1;
        end
        if (t >= {2'b00, mm}) t = t - {2'b00, mm};
        return t[W-1:0];
    endfunction

    function automatic logic [W-1:0] calc_r2(input logic [W-1:0] mm);
        logic [W+1:0] r;
        r = 1;
        for (int k = 0; k < 512; k++) begin
            r = r << 1;
            if (r >= {2'b00, mm}) r = r - {2'b00, mm};
        end
        return r[W-1:0];
    endfunction

    function automatic int exp_pulses(input logic [W-1:0] e);
        int pc;
        int top;
        pc  = 0;
        top = -1;
        for (int k = 0; k < EB; k++) begin
            if (e[k]) begin
                pc++;
                top = k;
            end
        end
`ifdef MONT_POW_SKIP_LZ_EN
        return 3 + (top + 1) + pc;
`else
        return 3 + EB + pc + 0 * top;
`endif
    endfunction

    // Behavioural multiplier: done drops the cycle after start, returns after a fixed latency.
    int           mlat;
    logic [W-1:0] ma, mb, mm_l;
    always @(posedge clk) begin
        if (reset) begin
            mul_done   <= 1'b1;
            mul_result <= '0;
            mlat       <= 0;
        end else if (mul_start && mul_done) begin
            ma       <= mul_a;
            mb       <= mul_b;
            mm_l     <= mul_m;
            mul_done <= 1'b0;
            mlat     <= 3;
        end else if (!mul_done) begin
            if (mlat == 0) begin
                mul_done   <= 1'b1;
                mul_result <= mont(ma, mb, mm_l);
            end else begin
                mlat <= mlat - 1;
            end
        end
    end

    always @(posedge clk) begin
        if (reset) pulse_cnt <= 0;
        else if (mul_start) pulse_cnt <= pulse_cnt + 1;
    end

    task automatic cmp(input string n, input logic [W-1:0] a, input logic [W-1:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", n, a, e);
        end
    endtask

    chk_t c;
    job_t j;
    always @(negedge clk) begin
        while (chk_q.size() > 0) begin
            c = chk_q.pop_front();
            cmp(c.name, c.act, c.expv);
        end
        if (mul_start) cmp("issue_when_ready", W'(mul_done), W'(1));
        if (reset) begin
            pulse_base = 0;
        end else if (done && !done_prev) begin
            if (job_q.size() > 0) begin
                j = job_q.pop_front();
                cmp("result", result, j.res);
                cmp("pulse_count", W'(pulse_cnt - pulse_base), W'(j.pulses));
            end
            pulse_base = pulse_cnt;
        end
        done_prev = done;
    end

    task automatic push_chk(input string n, input logic [W-1:0] a, input logic [W-1:0] e);
        chk_q.push_back('{n, a, e});
    endtask

    task automatic wait_idle();
        int k = 0;
        while (!done && k < 10000) begin
            @(negedge clk);
            k++;
        end
        if (!done) push_chk("idle_timeout", W'(0), W'(1));
    endtask

    task automatic wait_jobs();
        int k = 0;
        while (job_q.size() != 0 && k < 8000) begin
            @(negedge clk);
            k++;
        end
        if (job_q.size() != 0) begin
            push_chk("job_timeout", W'(job_q.size()), W'(0));
            job_q.delete();
        end
    endtask

    task automatic run_job(input logic [W-1:0] b, input logic [W-1:0] e,
                           input logic [W-1:0] mm, input logic [W-1:0] er);
        wait_idle();
        base  = b;
        exp   = e;
        m     = mm;
        r2    = calc_r2(mm);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        job_q.push_back('{er, exp_pulses(e)});
        push_chk("busy_done_low", W'(done), W'(0));
        base = W'(3);
        exp  = W'(7);
        m    = W'(11);
        r2   = W'(5);
        repeat (20) @(negedge clk);
        push_chk("result_hold", result, last_res);
        wait_jobs();
        last_res = er;
    endtask

    logic [W-1:0] m13, m25519;

    initial begin
        m13    = W'(13);
        m25519 = (W'(1) << 255) - W'(19);
        reset  = 1'b1;
        start  = 1'b0;
        base   = '0;
        exp    = '0;
        m      = '0;
        r2     = '0;
        last_res = '0;
        repeat (3) @(negedge clk);
        push_chk("rst_result", result, W'(0));
        push_chk("rst_done", W'(done), W'(0));
        push_chk("rst_mul_start", W'(mul_start), W'(0));
        push_chk("rst_mul_a", mul_a, W'(0));
        push_chk("rst_mul_b", mul_b, W'(0));
        push_chk("rst_mul_m", mul_m, W'(0));
        reset = 1'b0;

        run_job(W'(4), W'(3), m13, W'(12));
        run_job(W'(7), W'(0), m13, W'(1));
        run_job(W'(0), W'(5), m13, W'(0));
        run_job(W'(2), W'(11), m25519, W'(2048));

        // abort mid-exponentiation
        wait_idle();
        base  = W'(4);
        exp   = W'(3);
        m     = m13;
        r2    = calc_r2(m13);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (100) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        push_chk("abort_result", result, W'(0));
        push_chk("abort_done", W'(done), W'(0));
        push_chk("abort_mul_start", W'(mul_start), W'(0));
        push_chk("abort_mul_a", mul_a, W'(0));
        push_chk("abort_mul_b", mul_b, W'(0));
        push_chk("abort_mul_m", mul_m, W'(0));
        reset    = 1'b0;
        last_res = '0;
        run_job(W'(4), W'(3), m13, W'(12));

        // start held across two jobs; second job's inputs set while the first is busy
        wait_idle();
        base  = W'(4);
        exp   = W'(3);
        m     = m13;
        r2    = calc_r2(m13);
        start = 1'b1;
        @(negedge clk);
        job_q.push_back('{W'(12), exp_pulses(W'(3))});
        job_q.push_back('{W'(12), exp_pulses(W'(2))});
        base = W'(5);
        exp  = W'(2);
        begin
            int k = 0;
            while (!done && k < 8000) begin
                @(negedge clk);
                k++;
            end
            if (!done) push_chk("held_first_timeout", W'(0), W'(1));
        end
        @(negedge clk);
        push_chk("held_single_idle", W'(done), W'(0));
        start = 1'b0;
        wait_jobs();

        repeat (5) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
